// File: rtl/pipe_stage_skid.sv
// Reusable pipeline stage register with valid/ready handshake, stall and flush.
// Define PIPE_SKID_EN for the two-entry skid buffer with a registered in_ready.
module pipe_stage_skid #(
    parameter int                 DATA_W  = 64,
    parameter logic [DATA_W-1:0]  RST_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              stall,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [DATA_W-1:0]  main_r;
    logic               out_valid_r;
    logic [1:0]         occ_r;
    logic [1:0]         occ_s;
    logic               acc_s;
    logic               adv_s;
    logic               in_ready_s;
    logic               load_in_s;
`ifdef PIPE_SKID_EN
    logic [DATA_W-1:0]  skid_r;
    logic               in_ready_r;
    logic               load_skid_s;
    logic               skid_to_main_s;
`endif

    assign adv_s = out_valid_r & out_ready & ~stall;
`ifdef PIPE_SKID_EN
    // Registered ready breaks the combinational stall chain back to upstream.
    assign in_ready_s = in_ready_r;
`else
    assign in_ready_s = ~out_valid_r | (out_ready & ~stall);
`endif
    assign acc_s     = in_valid & in_ready_s;
    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = main_r;
    assign occupancy = occ_r;

    // Next-state and storage-load decode; flush empties the stage and drops any same-cycle acceptance.
    always_comb begin
        state_s   = state_r;
        load_in_s = 1'b0;
`ifdef PIPE_SKID_EN
        load_skid_s    = 1'b0;
        skid_to_main_s = 1'b0;
`endif
        if (flush) begin
            state_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (acc_s) begin
                        state_s   = ST_ONE;
                        load_in_s = 1'b1;
                    end else begin
                        state_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (acc_s && adv_s) begin
                        state_s   = ST_ONE;
                        load_in_s = 1'b1;
                    end else if (acc_s) begin
`ifdef PIPE_SKID_EN
                        state_s     = ST_TWO;
                        load_skid_s = 1'b1;
`else
                        state_s = ST_ONE;
`endif
                    end else if (adv_s) begin
                        state_s = ST_EMPTY;
                    end else begin
                        state_s = ST_ONE;
                    end
                end
`ifdef PIPE_SKID_EN
                ST_TWO: begin
                    if (adv_s) begin
                        state_s        = ST_ONE;
                        skid_to_main_s = 1'b1;
                    end else begin
                        state_s = ST_TWO;
                    end
                end
`endif
                default: begin
                    state_s = ST_EMPTY;
                end
            endcase
        end
    end

    // Occupancy encoding of the next state, so the output can be registered.
    always_comb begin
        case (state_s)
            ST_ONE:  occ_s = 2'd1;
            ST_TWO:  occ_s = 2'd2;
            default: occ_s = 2'd0;
        endcase
    end

    // State, main payload register and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_EMPTY;
            main_r      <= RST_VAL;
            out_valid_r <= 1'b0;
            occ_r       <= 2'd0;
        end else begin
            state_r     <= state_s;
            out_valid_r <= (state_s != ST_EMPTY);
            occ_r       <= occ_s;
            if (load_in_s) begin
                main_r <= in_data;
`ifdef PIPE_SKID_EN
            end else if (skid_to_main_s) begin
                main_r <= skid_r;
`endif
            end else begin
                main_r <= main_r;
            end
        end
    end

`ifdef PIPE_SKID_EN
    // Skid entry and ready flag; ready is low exactly while the stage is full.
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_r     <= RST_VAL;
            in_ready_r <= 1'b1;
        end else begin
            in_ready_r <= (state_s != ST_TWO);
            if (load_skid_s) begin
                skid_r <= in_data;
            end else begin
                skid_r <= skid_r;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid; works with and without PIPE_SKID_EN.
module tb_pipe_stage_skid;

    localparam int          DATA_W  = 16;
    localparam logic [15:0] RST_VAL = 16'hBEEF;
`ifdef PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush = 1'b0;
    logic              stall = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;

    pipe_stage_skid #(.DATA_W(DATA_W), .RST_VAL(RST_VAL)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] send_q[$];
    logic [DATA_W-1:0] sb_q[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  m_occ = 0;
    bit  m_in_ready;
    bit  m_acc;
    bit  m_adv;
    bit  chk_en = 1'b0;
    bit  rand_gaps = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive from send_q, check outputs against the model, update model on the edge.
    task automatic tick();
        if (send_q.size() > 0 && !(rand_gaps && $urandom_range(0, 3) == 0)) begin
            in_valid = 1'b1;
            in_data  = send_q[0];
        end else begin
            in_valid = 1'b0;
        end
        #1;
        m_in_ready = SKID ? (m_occ != 2) : (m_occ == 0 || (out_ready && !stall));
        if (chk_en) begin
            check_val("in_ready", 64'(in_ready), 64'(m_in_ready));
            check_val("out_valid", 64'(out_valid), 64'(m_occ != 0));
            check_val("occupancy", 64'(occupancy), 64'(m_occ));
            if (m_occ != 0 && sb_q.size() > 0)
                check_val("out_data", 64'(out_data), 64'(sb_q[0]));
        end
        m_acc = in_valid && m_in_ready;
        m_adv = (m_occ != 0) && out_ready && !stall;
        @(posedge clk);
        if (m_acc) void'(send_q.pop_front());
        if (rst || flush) begin
            sb_q.delete();
            m_occ = 0;
        end else begin
            if (m_adv) void'(sb_q.pop_front());
            if (m_acc) sb_q.push_back(in_data);
            m_occ = m_occ + int'(m_acc) - int'(m_adv);
        end
        chk_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // Reset held two cycles with a live word presented
        rst = 1'b1;
        send_q.push_back(16'h00AA);
        send_q.push_back(16'h00AA);
        run(2);
        rst = 1'b0;
        send_q.delete();
        #1;
        check_val("rst_out_data", 64'(out_data), 64'(RST_VAL));
        check_val("rst_in_ready", 64'(in_ready), 64'd1);
        check_val("rst_occ", 64'(occupancy), 64'd0);
        run(2);

        // Streaming 1..8
        for (int i = 1; i <= 8; i++) send_q.push_back(DATA_W'(i));
        run(10);
        check_val("stream_drained", 64'(sb_q.size()), 64'd0);

        // Stall with back-pressure, then release
        stall = 1'b1;
        send_q.push_back(16'h0010);
        send_q.push_back(16'h0011);
        send_q.push_back(16'h0012);
        run(4);
        check_val("stall_pending", 64'(send_q.size()), SKID ? 64'd1 : 64'd2);
        stall = 1'b0;
        run(6);
        check_val("stall_drained", 64'(sb_q.size() + send_q.size()), 64'd0);

        // Flush while full, with a word offered in the flush cycle
        stall = 1'b1;
        send_q.push_back(16'h00A0);
        send_q.push_back(16'h00A1);
        run(3);
        send_q.delete();
        send_q.push_back(16'h0055);
        flush = 1'b1;
        run(1);
        flush = 1'b0;
        stall = 1'b0;
        send_q.delete();
        run(3);

        // Simultaneous accept and advance in ONE
        out_ready = 1'b0;
        send_q.push_back(16'h0020);
        run(2);
        out_ready = 1'b1;
        send_q.push_back(16'h0021);
        run(1);
        run(2);

        // out_ready toggling while holding a word
        out_ready = 1'b0;
        send_q.push_back(16'h0030);
        run(2);
        send_q.push_back(16'h0031);
        out_ready = 1'b1;
        run(1);
        out_ready = 1'b0;
        run(1);
        out_ready = 1'b1;
        run(2);

        // Random traffic with stalls, back-pressure and rare flushes
        rand_gaps = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if (send_q.size() < 2) send_q.push_back(DATA_W'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            stall     = ($urandom_range(0, 5) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            tick();
        end
        flush = 1'b0;
        stall = 1'b0;
        out_ready = 1'b1;
        rand_gaps = 1'b0;
        send_q.delete();
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) tick();
        check_val("final_drain", 64'(sb_q.size()), 64'd0);

        // Reset mid-transfer
        stall = 1'b1;
        send_q.push_back(16'h0077);
        send_q.push_back(16'h0078);
        run(3);
        rst = 1'b1;
        send_q.delete();
        run(1);
        rst = 1'b0;
        stall = 1'b0;
        #1;
        check_val("rst2_out_data", 64'(out_data), 64'(RST_VAL));
        run(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register with a valid/ready handshake, an external stall, a flush, and an optional two-entry skid buffer. It generalises the fixed-payload, stall-only inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) into one reusable stage. It adds flush, back-pressure propagation, and a registered ready path so long stall chains (DCache miss to IF) no longer form one combinational net. Instances sit between any two pipeline stages; the payload is the stage's concatenated fields.

## Interface
Parameters:
- DATA_W, 64, payload width in bits (≥1)
- RST_VAL, {DATA_W{1'b0}}, payload value after reset (e.g. PC_RST in the PC field)

Ports:
- clk  in  1  clock, all state on posedge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- flush  in  1  discard every held entry (branch mispredict / exception)
- stall  in  1  downstream hold (e.g. DCache miss); equivalent to out_ready=0
- in_valid  in  1  upstream payload valid
- in_ready  out  1  stage can accept this cycle
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  out_data holds a live entry
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  payload to next stage
- occupancy  out  2  entries held, 0..2

## Operation
- acc = in_valid & in_ready; adv = out_valid & out_ready & !stall.
- Storage: main register (drives out_data) plus skid register (PIPE_SKID_EN only).
- States: EMPTY (occ 0), ONE (occ 1), TWO (occ 2, skid only).
- EMPTY: acc → ONE, main<=in_data.
- ONE: acc&adv → ONE, main<=in_data; acc&!adv → TWO, skid<=in_data; !acc&adv → EMPTY; else hold.
- TWO: in_ready=0, so no acc; adv → ONE, main<=skid; else hold.
- Priority: rst > flush > normal transitions.
- flush: next state EMPTY, out_valid=0, in_ready=1; a same-cycle acc is dropped; main/skid data hold their old values.
- Hold rule: while out_valid & !(out_ready & !stall), out_data is stable.
- Ordering: entries leave in acceptance order; none is dropped or duplicated except by flush/rst.

## Timing
- Reset values (cycle after rst high): out_valid=0, out_data=RST_VAL, skid=RST_VAL, occupancy=0, in_ready=1.
- A word accepted in rst's cycle is discarded.
- Latency in_data→out_data: 1 cycle. Throughput: 1 word/cycle while downstream accepts.
- With skid: in_ready is a register; it is 0 exactly when state is TWO. It drops the cycle after a stalled acceptance and rises the cycle after the first adv from TWO.
- With skid, there is no combinational path from out_ready/stall to in_ready.
- Simultaneous acc & adv in ONE keeps occupancy at 1 with no bubble.
- flush & adv in the same cycle: the downstream handshake completes, then the stage is EMPTY.
- rst mid-transfer (any state) → EMPTY next cycle with reset values.

## Configuration
- PIPE_SKID_EN defined: two-entry skid buffer as above; in_ready registered; occupancy 0..2.
- Not defined: single register; state TWO unreachable; occupancy ≤1.
  - in_ready = !out_valid | (out_ready & !stall), combinational.
  - All other rules unchanged: 1-cycle latency, flush/rst priority, reset values.

## Test plan
- Reset: hold rst 2 cycles with in_valid=1, in_data=0xAA → out_valid=0, out_data=RST_VAL, in_ready=1, occupancy=0; the 0xAA word never appears.
- Streaming: 8 back-to-back words 1..8 with out_ready=1, stall=0 → out_data 1..8 on consecutive cycles, each 1 cycle after acceptance, occupancy=1 throughout.
- Stall with skid: send 0x10, 0x11, 0x12 while stall=1 from cycle 1 → 0x10 held on out_data, 0x11 in skid, occupancy=2, in_ready=0, 0x12 not accepted. Release stall → 0x10, 0x11, 0x12 delivered in order, no loss.
- Flush: occupancy=2, then flush=1 with in_valid=1, in_data=0x55 → next cycle out_valid=0, occupancy=0, in_ready=1; 0x55 never output.
- Simultaneous: state ONE holding 0x20; in_valid=1 (0x21) with out_ready=1 → next cycle out_data=0x21, occupancy=1.
- Build without PIPE_SKID_EN: with out_valid=1, toggle out_ready 1→0 → in_ready follows in the same cycle; occupancy never exceeds 1.
